// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: byte-lane store formatting, load extraction and a
// req/gnt/rvalid data-memory handshake. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
    parameter int XLEN     = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic            memwrite,
    input  logic            memtoreg,
    input  logic [1:0]      lwhb,
    input  logic [1:0]      swhb,
    input  logic            lunsigned,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      rd,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            ld_valid,
    output logic [XLEN-1:0] ld_data,
    output logic [4:0]      ld_rd,
    output logic            bus_err,
    output logic            misalign
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE, SZ_NONE} size_t;

    state_t          r_state, w_next;
    size_t           w_size, r_size;
    logic [CW-1:0]   r_cnt;
    logic            r_we, r_unsigned, r_bus_err, r_misalign;
    logic [1:0]      r_off;
    logic [4:0]      r_rd;
    logic [3:0]      r_be, w_be;
    logic [XLEN-1:0] r_addr, r_wdata, w_wdata, w_ext;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            w_accept, w_misalign_hit, w_timeout, w_ld_hit, w_to;

    assign w_accept  = (r_state == S_IDLE) && req_valid && (memwrite || memtoreg);
    assign w_timeout = (r_cnt == CW'(WAIT_MAX - 1));

    // Store wins when both memwrite and memtoreg are set.
    always_comb begin
        w_size = SZ_WORD;
        if (memwrite) begin
            case (swhb)
                2'b01:   w_size = SZ_WORD;
                2'b10:   w_size = SZ_HALF;
                2'b11:   w_size = SZ_BYTE;
                default: w_size = SZ_NONE;
            endcase
        end else begin
            case (lwhb)
                2'b01:   w_size = SZ_HALF;
                2'b10:   w_size = SZ_BYTE;
                default: w_size = SZ_WORD;
            endcase
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        case (w_size)
            SZ_HALF: begin
                w_be    = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {(XLEN/16){wdata[15:0]}};
            end
            SZ_BYTE: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {(XLEN/8){wdata[7:0]}};
            end
            SZ_NONE: w_be = 4'b0000;
            default: w_be = 4'b1111;
        endcase
        if (!memwrite) w_be = 4'b1111;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign_hit = w_accept &&
        (((w_size == SZ_HALF) && addr[0]) || ((w_size == SZ_WORD) && (addr[1:0] != 2'b00)));
`else
    assign w_misalign_hit = 1'b0;
`endif

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        w_next   = r_state;
        w_ld_hit = 1'b0;
        w_to     = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept && !w_misalign_hit) w_next = S_REQ;
            S_REQ: begin
                if (dmem_gnt) begin
                    if (r_we) begin
                        w_next = S_IDLE;
                    end else if (dmem_rvalid) begin
                        w_next   = S_IDLE;
                        w_ld_hit = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                    w_to   = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_rvalid) begin
                    w_next   = S_IDLE;
                    w_ld_hit = 1'b1;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                    w_to   = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: synchronous reset, sampled only at the clock edge; state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= SZ_WORD;
            r_off      <= 2'b00;
            r_rd       <= '0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_bus_err  <= w_to;
            r_misalign <= w_misalign_hit;
            if (w_next != r_state)      r_cnt <= '0;
            else if (r_state != S_IDLE) r_cnt <= r_cnt + CW'(1);
            if (w_accept) begin
                r_we       <= memwrite;
                r_unsigned <= lunsigned;
                r_size     <= w_size;
                r_off      <= addr[1:0];
                r_rd       <= rd;
                r_be       <= w_be;
                r_addr     <= {addr[XLEN-1:2], 2'b00};
                r_wdata    <= w_wdata;
            end
        end
    end

    assign w_byte = dmem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = dmem_rdata[{r_off[1], 4'b0000} +: 16];

    always_comb begin
        case (r_size)
            SZ_BYTE: w_ext = {{(XLEN-8){w_byte[7] & ~r_unsigned}}, w_byte};
            SZ_HALF: w_ext = {{(XLEN-16){w_half[15] & ~r_unsigned}}, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    assign stall      = (r_state != S_IDLE);
    assign dmem_req   = (r_state == S_REQ);
    assign dmem_we    = r_we;
    assign dmem_be    = r_be;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign ld_valid   = w_ld_hit;
    assign ld_data    = w_ld_hit ? w_ext : '0;
    assign ld_rd      = w_ld_hit ? r_rd : '0;
    assign bus_err    = r_bus_err;
    assign misalign   = r_misalign;
endmodule
